// File: rtl/clause_energy_evaluator_pkg.sv
// Shared defaults, derived widths and state encoding for the clause energy evaluator.
package clause_energy_evaluator_pkg;

  localparam int NUMBER_OF_INTEGER_VARIABLES   = 2;
  localparam int BIT_WIDTH_OF_INTEGER_VARIABLE = 8;
  localparam int NUMBER_OF_CLAUSE_PAIRS        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A single-pair ROM still needs a one-bit address port.
  function automatic int addr_width(input int pairs);
    return (pairs > 1) ? $clog2(pairs) : 1;
  endfunction

  function automatic int energy_width(input int pairs);
    return $clog2(2 * pairs + 1);
  endfunction

endpackage

// File: rtl/clause_energy_evaluator_checker.sv
// Evaluates two linear clauses against an assignment and registers the satisfied flags.
// Field i (i < N) is the coefficient of y(i+1); field N is the constant term c0.
// A clause is satisfied when c0 + sum(c_i * y_i) <= 0.
module clause_energy_evaluator_checker #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 valid_i,
  input  logic [(N+1)*W-1:0]   clause1_i,
  input  logic [(N+1)*W-1:0]   clause2_i,
  input  logic [N*W-1:0]       assignment_i,
  output logic                 sat1_o,
  output logic                 sat2_o,
  output logic                 valid_o
);

  localparam int SW = 2 * W + $clog2(N + 1) + 1;

  logic sat1_q, sat2_q, valid_q;
  logic sat1_d, sat2_d, valid_d;

  function automatic logic clause_sat(input logic [(N+1)*W-1:0] c,
                                      input logic [N*W-1:0]     y);
    logic signed [SW-1:0] acc;
    acc = SW'(signed'(c[N*W +: W]));
    for (int i = 0; i < N; i++) begin
      acc = acc + SW'(signed'(c[i*W +: W])) * SW'(signed'(y[i*W +: W]));
    end
    return (acc == '0) || acc[SW-1];
  endfunction

  always_comb begin
    sat1_d  = sat1_q;
    sat2_d  = sat2_q;
    valid_d = valid_q;
    if (enable_i) begin
      sat1_d  = clause_sat(clause1_i, assignment_i);
      sat2_d  = clause_sat(clause2_i, assignment_i);
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sat1_q  <= 1'b0;
      sat2_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sat1_q  <= sat1_d;
      sat2_q  <= sat2_d;
      valid_q <= valid_d;
    end
  end

  assign sat1_o  = sat1_q;
  assign sat2_o  = sat2_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/clause_energy_evaluator.sv
// Walks the clause ROM one pair per cycle and counts violated clauses (MCMC energy).
// state | meaning: IDLE wait start | FETCH issue addr 0..P-1 | DRAIN finish pipeline | DONE pulse
module clause_energy_evaluator
  import clause_energy_evaluator_pkg::*;
#(
  parameter int NUMBER_OF_INTEGER_VARIABLES   = clause_energy_evaluator_pkg::NUMBER_OF_INTEGER_VARIABLES,
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = clause_energy_evaluator_pkg::BIT_WIDTH_OF_INTEGER_VARIABLE,
  parameter int NUMBER_OF_CLAUSE_PAIRS        = clause_energy_evaluator_pkg::NUMBER_OF_CLAUSE_PAIRS,
  parameter int ADDR_WIDTH                    = addr_width(NUMBER_OF_CLAUSE_PAIRS),
  parameter int ENERGY_WIDTH                  = energy_width(NUMBER_OF_CLAUSE_PAIRS)
) (
  input  logic                                                            in_clk,
  input  logic                                                            in_reset,
  input  logic                                                            in_enable,
  input  logic                                                            in_start,
  input  logic [NUMBER_OF_INTEGER_VARIABLES*BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     in_current_assignment,
  output logic [ADDR_WIDTH-1:0]                                           out_rom_addr,
  output logic                                                            out_rom_en,
  input  logic [(NUMBER_OF_INTEGER_VARIABLES+1)*BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_coefficients_clause1,
  input  logic [(NUMBER_OF_INTEGER_VARIABLES+1)*BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_coefficients_clause2,
  output logic                                                            out_busy,
  output logic                                                            out_done,
  output logic [ENERGY_WIDTH-1:0]                                         out_energy,
  output logic                                                            out_all_satisfied
);

  localparam int N  = NUMBER_OF_INTEGER_VARIABLES;
  localparam int W  = BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int EW = ENERGY_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUMBER_OF_CLAUSE_PAIRS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [N*W-1:0]        assign_q, assign_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [EW-1:0]         energy_q, energy_d;
  logic                  all_sat_q, all_sat_d;
  logic                  rom_en, done;
  logic                  sat1, sat2, flag_valid;

  clause_energy_evaluator_checker #(.N(N), .W(W)) u_checker (
    .clk_i        (in_clk),
    .reset_i      (in_reset),
    .enable_i     (in_enable),
    .valid_i      (rd_valid_q),
    .clause1_i    (in_coefficients_clause1),
    .clause2_i    (in_coefficients_clause2),
    .assignment_i (assign_q),
    .sat1_o       (sat1),
    .sat2_o       (sat2),
    .valid_o      (flag_valid)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    assign_d   = assign_q;
    rd_valid_d = rd_valid_q;
    energy_d   = energy_q;
    all_sat_d  = all_sat_q;
    rom_en     = 1'b0;
    done       = 1'b0;
    if (in_enable) begin
      rd_valid_d = 1'b0;
      if (flag_valid) begin
        energy_d = energy_q + EW'(~sat1) + EW'(~sat2);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (in_start) begin
            state_d   = ST_FETCH;
            addr_d    = '0;
            assign_d  = in_current_assignment;
            energy_d  = '0;
            all_sat_d = 1'b0;
          end
        end
        ST_FETCH: begin
          rom_en     = 1'b1;
          rd_valid_d = 1'b1;
          if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
        ST_DRAIN: begin
          // Last pair is being accumulated once no ROM read is still in flight.
          if (flag_valid && !rd_valid_q) begin
            state_d   = ST_DONE;
            all_sat_d = (energy_d == '0);
          end
        end
        ST_DONE: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      assign_q   <= '0;
      rd_valid_q <= 1'b0;
      energy_q   <= '0;
      all_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      assign_q   <= assign_d;
      rd_valid_q <= rd_valid_d;
      energy_q   <= energy_d;
      all_sat_q  <= all_sat_d;
    end
  end

  assign out_rom_addr      = addr_q;
  assign out_rom_en        = rom_en;
  assign out_busy          = (state_q != ST_IDLE);
  assign out_done          = done;
  assign out_energy        = energy_q;
  assign out_all_satisfied = all_sat_q;

endmodule

// File: tb/tb_clause_energy_evaluator.sv
// Randomized and directed checks of clause_energy_evaluator (P=2, N=2, W=8) against a clause-count model.
module tb_clause_energy_evaluator;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int P  = 2;
  localparam int AW = 1;
  localparam int EW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b1;
  logic              start = 1'b0;
  logic [N*W-1:0]    assignment = '0;
  logic [AW-1:0]     rom_addr;
  logic              rom_en;
  logic [(N+1)*W-1:0] c1 = '0, c2 = '0;
  logic              busy, done, all_sat;
  logic [EW-1:0]     energy;

  logic [(N+1)*W-1:0] rom1 [P];
  logic [(N+1)*W-1:0] rom2 [P];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clause_energy_evaluator #(
    .NUMBER_OF_INTEGER_VARIABLES  (N),
    .BIT_WIDTH_OF_INTEGER_VARIABLE(W),
    .NUMBER_OF_CLAUSE_PAIRS       (P),
    .ADDR_WIDTH                   (AW),
    .ENERGY_WIDTH                 (EW)
  ) dut (
    .in_clk                 (clk),
    .in_reset               (rst),
    .in_enable              (enable),
    .in_start               (start),
    .in_current_assignment  (assignment),
    .out_rom_addr           (rom_addr),
    .out_rom_en             (rom_en),
    .in_coefficients_clause1(c1),
    .in_coefficients_clause2(c2),
    .out_busy               (busy),
    .out_done               (done),
    .out_energy             (energy),
    .out_all_satisfied      (all_sat)
  );

  // Synchronous ROM: data one cycle after the address, held while disabled.
  always @(posedge clk) begin
    if (rom_en) begin
      c1 <= rom1[rom_addr];
      c2 <= rom2[rom_addr];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit clause_ok(input logic [(N+1)*W-1:0] c, input logic [N*W-1:0] y);
    int s;
    s = int'($signed(c[N*W +: W]));
    for (int i = 0; i < N; i++)
      s += int'($signed(c[i*W +: W])) * int'($signed(y[i*W +: W]));
    return s <= 0;
  endfunction

  function automatic int model_energy(input logic [N*W-1:0] y);
    int e = 0;
    for (int k = 0; k < P; k++) begin
      if (!clause_ok(rom1[k], y)) e++;
      if (!clause_ok(rom2[k], y)) e++;
    end
    return e;
  endfunction

  // Start a run, optionally stall [s0, s0+sl) and poke start while busy / in DONE.
  task automatic run(input logic [N*W-1:0] a, input int s0, input int sl, input bit poke,
                     output int lat, output int e, output int sat);
    lat = -1; e = -1; sat = -1;
    @(negedge clk);
    start = 1'b1;
    assignment = a;
    @(posedge clk);
    #1 start = 1'b0;
    assignment = ~a;
    for (int c = 1; c <= 40; c++) begin
      enable = !(c >= s0 && c < s0 + sl);
      start  = poke && (c == 2);
      @(negedge clk);
      if (c == 1) check("busy_after_start", busy, 1);
      if (done) begin
        lat = c; e = energy; sat = all_sat;
        break;
      end
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    if (lat >= 0) begin
      start = poke;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("energy_hold", energy, e);
      @(negedge clk);
      check("idle_after_done", busy, 0);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, e, sat, e_ref, dones;
    logic [N*W-1:0] a;

    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_done", done, 0);
    end
    check("rst_busy", busy, 0);
    check("rst_energy", energy, 0);
    check("rst_all_sat", all_sat, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    rom1[0] = 24'h020101; rom2[0] = 24'h010101;
    rom1[1] = 24'h020101; rom2[1] = 24'h010101;
    run(16'hffff, 0, 0, 1'b0, lat, e, sat);
    check("t1_lat", lat, P + 3);
    check("t1_energy", e, 0);
    check("t1_sat", sat, 1);
    check("t1_model", e, model_energy(16'hffff));

    run(16'h0101, 0, 0, 1'b0, lat, e, sat);
    check("t2_lat", lat, P + 3);
    check("t2_energy", e, 4);
    check("t2_sat", sat, 0);

    rom2[0] = 24'h030101;
    run(16'hffff, 0, 0, 1'b0, lat, e, sat);
    check("t3_energy", e, 1);
    check("t3_sat", sat, 0);
    e_ref = e;

    run(16'hffff, 2, 3, 1'b0, lat, e, sat);
    check("stall_lat", lat, P + 3 + 3);
    check("stall_energy", e, e_ref);

    run(16'hffff, 0, 0, 1'b1, lat, e, sat);
    check("poke_lat", lat, P + 3);
    check("poke_energy", e, e_ref);

    // Reset in the first FETCH cycle aborts the run.
    @(negedge clk);
    start = 1'b1;
    assignment = 16'h0101;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_done_c1", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_energy", energy, 0);
    check("midrst_rom_en", rom_en, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", dones, 0);

    for (int it = 0; it < 24; it++) begin
      int s0, sl;
      for (int k = 0; k < P; k++) begin
        rom1[k] = 24'($urandom);
        rom2[k] = 24'($urandom);
      end
      a  = 16'($urandom);
      s0 = $urandom_range(1, 5);
      sl = $urandom_range(0, 3);
      e_ref = model_energy(a);
      run(a, s0, sl, it[0], lat, e, sat);
      check("rnd_lat", lat, P + 3 + sl);
      check("rnd_energy", e, e_ref);
      check("rnd_sat", sat, (e_ref == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
